timer_counter: RTL and testbench

//  Memory-mapped countdown timer; the device-side responder behind the CPU bridge.

---
 rtl/timer_counter.sv | 116 +++++++++++
 tb/tb_timer_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT window at BASE, interrupt on expiry.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (PRESCALE_DIV clocks per decrement).
module timer_counter #(
  parameter logic [31:0] BASE         = 32'h0000_7F00,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e      state_q;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q;
  logic        flag_q;
  logic        tick;

  logic [31:0] off;
  logic        in_win, wr_ctrl, wr_preset;
  logic        en, im, reload;

  // Unsigned subtract folds both window bounds into a single compare.
  assign off       = addr - BASE;
  assign in_win    = (off < 32'd12);
  assign wr_ctrl   = we && in_win && (off[3:2] == 2'd0);
  assign wr_preset = we && in_win && (off[3:2] == 2'd1);

  assign en     = ctrl_q[0];
  assign im     = ctrl_q[3];
  assign reload = (ctrl_q[2:1] == 2'd1);

  always_comb begin
    rd = '0;
    if (in_win) begin
      case (off[3:2])
        2'd0:    rd = {28'b0, ctrl_q};
        2'd1:    rd = preset_q;
        2'd2:    rd = count_q;
        default: rd = '0;
      endcase
    end
  end

  // A CPU write to CTRL overrides the one-shot EN clear on the same edge.
  always_comb begin
    ctrl_d = ctrl_q;
    if (state_q == S_INT && !reload) ctrl_d[0] = 1'b0;
    if (wr_ctrl) ctrl_d = wd[3:0];
    preset_d = wr_preset ? wd : preset_q;
  end

`ifdef TIMER_PRESCALE_EN
  logic [31:0] pre_q;

  assign tick = (pre_q == PRESCALE_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else if (state_q == S_LOAD) begin
      pre_q <= '0;
    end else if (state_q == S_CNT && en) begin
      pre_q <= tick ? 32'd0 : pre_q + 32'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      if (wr_ctrl || wr_preset) flag_q <= 1'b0;
      case (state_q)
        S_IDLE: if (en) state_q <= S_LOAD;
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            // Expiry is reached from 1 or 0 alike, so COUNT never underflows.
            if (count_q <= 32'd1) begin
              count_q <= '0;
              state_q <= S_INT;
              flag_q  <= 1'b1;
            end else begin
              count_q <= count_q - 32'd1;
            end
          end
        end
        S_INT:   state_q <= reload ? S_LOAD : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq = im & (reload ? (state_q == S_INT) : flag_q);

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expected values queued with stimulus, popped at observation.
module tb_timer_counter;

  localparam logic [31:0] A_CTRL   = 32'h7F00;
  localparam logic [31:0] A_PRESET = 32'h7F04;
  localparam logic [31:0] A_COUNT  = 32'h7F08;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  timer_counter #(.BASE(32'h0000_7F00), .PRESCALE_DIV(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd), .irq(irq)
  );

  always #5 clk = ~clk;

  // Drive at a negedge; the write lands on the following posedge; returns at the next negedge.
  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0; wd = '0;
  endtask

  task automatic rd_bus(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd;
  endtask

  task automatic test_reset;
    logic [31:0] v, e;
    reset = 1'b1; we = 1'b0; addr = '0; wd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      rd_bus(A_CTRL + 32'(4 * i), v);
      e = sb_q.pop_front();
      n_tests++;
      if (v !== e) begin n_fail++; $display("FAIL reset_rd[%0d] got %h exp %h", i, v, e); end
    end
    e = sb_q.pop_front();
    n_tests++;
    if ({31'b0, irq} !== e) begin n_fail++; $display("FAIL reset_irq got %b exp %h", irq, e); end
  endtask

  // Queue an irq trace of `lat-1` lows then a high, then compare one sample per clock.
  task automatic run_oneshot(input logic [31:0] preset, input int lat, input string nm);
    logic [31:0] e;
    @(negedge clk);
    wr_bus(A_PRESET, preset);
    wr_bus(A_CTRL, 32'h9);
    for (int k = 1; k <= lat; k++) sb_q.push_back((k == lat) ? 32'h1 : 32'h0);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      e = sb_q.pop_front();
      n_tests++;
      if ({31'b0, irq} !== e) begin n_fail++; $display("FAIL %s irq@E%0d got %b exp %0d", nm, k, irq, e); end
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] v, e;
    run_oneshot(32'd5, 7, "oneshot");
    @(negedge clk);
    sb_q.push_back(32'h0); sb_q.push_back(32'h8); sb_q.push_back(32'h1);
    rd_bus(A_COUNT, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL oneshot_count got %h exp %h", v, e); end
    rd_bus(A_CTRL, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL oneshot_ctrl got %h exp %h", v, e); end
    repeat (3) @(negedge clk);
    e = sb_q.pop_front(); n_tests++;
    if ({31'b0, irq} !== e) begin n_fail++; $display("FAIL oneshot_irq_held got %b exp %0d", irq, e); end
    wr_bus(A_PRESET, 32'd5);
    sb_q.push_back(32'h0);
    e = sb_q.pop_front(); n_tests++;
    if ({31'b0, irq} !== e) begin n_fail++; $display("FAIL oneshot_irq_clear got %b exp %0d", irq, e); end
  endtask

  task automatic test_preset_zero;
    run_oneshot(32'd0, 3, "preset0");
    @(negedge clk);
    wr_bus(A_PRESET, 32'd1);
    run_oneshot(32'd1, 3, "preset1");
    @(negedge clk);
    wr_bus(A_PRESET, 32'd5);
  endtask

  task automatic test_decode;
    logic [31:0] v, e;
    wr_bus(32'h7F10, 32'hB);
    wr_bus(32'h7EFC, 32'hFFFF_FFFF);
    wr_bus(A_COUNT, 32'h1234);
    wr_bus(32'h7F0C, 32'hFFFF_FFFF);
    sb_q.push_back(32'h8); sb_q.push_back(32'd5); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    rd_bus(A_CTRL, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL decode_ctrl got %h exp %h", v, e); end
    rd_bus(A_PRESET, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL decode_preset got %h exp %h", v, e); end
    rd_bus(A_COUNT, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL decode_count got %h exp %h", v, e); end
    rd_bus(32'h7F0C, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL decode_hole got %h exp %h", v, e); end
    // Upper CTRL bits are write-ignored.
    wr_bus(A_CTRL, 32'hFFFF_FFF0);
    sb_q.push_back(32'h0);
    rd_bus(A_CTRL, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL decode_ctrl_upper got %h exp %h", v, e); end
  endtask

  task automatic test_autoreload;
    logic [31:0] v, e;
    wr_bus(A_PRESET, 32'd3);
    wr_bus(A_CTRL, 32'hB);
    for (int k = 1; k <= 15; k++) sb_q.push_back((k % 5 == 0) ? 32'h1 : 32'h0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      e = sb_q.pop_front(); n_tests++;
      if ({31'b0, irq} !== e) begin n_fail++; $display("FAIL autoreload irq@E%0d got %b exp %0d", k, irq, e); end
    end
    sb_q.push_back(32'hB);
    rd_bus(A_CTRL, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL autoreload_ctrl got %h exp %h", v, e); end
    wr_bus(A_CTRL, 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_race;
    logic [31:0] v, e;
    wr_bus(A_PRESET, 32'd2);
    wr_bus(A_CTRL, 32'h9);
    repeat (4) @(negedge clk);   // now in INT
    wr_bus(A_CTRL, 32'h9);       // lands on the edge INT would clear EN
    sb_q.push_back(32'h9); sb_q.push_back(32'd2); sb_q.push_back(32'h0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    rd_bus(A_CTRL, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL race_ctrl got %h exp %h", v, e); end
    repeat (2) @(negedge clk);
    rd_bus(A_COUNT, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL race_restart_count got %h exp %h", v, e); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_bus(A_COUNT, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL midreset_count got %h exp %h", v, e); end
    rd_bus(A_CTRL, v); e = sb_q.pop_front(); n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL midreset_ctrl got %h exp %h", v, e); end
    repeat (4) @(negedge clk);
    e = sb_q.pop_front(); n_tests++;
    if ({31'b0, irq} !== e) begin n_fail++; $display("FAIL midreset_irq got %b exp %0d", irq, e); end
  endtask

  task automatic test_prescale;
`ifdef TIMER_PRESCALE_EN
    run_oneshot(32'd2, 10, "prescale");
`else
    run_oneshot(32'd2, 4, "prescale");
`endif
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wd = '0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_decode();
    test_preset_zero();
    test_autoreload();
    test_race();
    test_prescale();
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
